// File: rtl/cache_mem_responder_pkg.sv
// Shared types for the cache-to-RAM memory responder: word type, FSM states and latched op.
package cache_mem_responder_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned STREAK_W = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {IDLE, SERV, IRESP, DRESP} memresp_state_t;

  typedef enum logic {OWNER_I, OWNER_D} memresp_owner_t;

  typedef struct packed {
    memresp_owner_t owner;
    logic           wen;
    word_t          addr;
    word_t          wdata;
  } memresp_op_t;

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache request/response lines plus the single-ported RAM handshake, seen from either side.
interface cache_mem_responder_if;
  import cache_mem_responder_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dwait;
  word_t dload;
  logic  ram_req;
  logic  ram_wen;
  word_t ram_addr;
  word_t ram_wdata;
  word_t ram_rdata;
  logic  ram_ready;

  // Responder side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    output iwait, iload, dwait, dload, ram_req, ram_wen, ram_addr, ram_wdata
  );

  // Caches and RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ram_rdata, ram_ready,
    input  iwait, iload, dwait, dload, ram_req, ram_wen, ram_addr, ram_wdata
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Arbitrates icache/dcache requests onto one RAM port; dcache first, with a streak
// limit so a waiting icache is granted after MAXD consecutive dcache grants.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int unsigned MAXD = 4
) (
  input logic                  CLK,
  input logic                  nRST,
  cache_mem_responder_if.slave bus
);

  memresp_state_t      state, state_d;
  memresp_op_t         op, op_d;
  word_t               resp, resp_d;
  logic [STREAK_W-1:0] dstreak, dstreak_d;

  logic  iwait_q, dwait_q, ram_req_q, ram_wen_q;
  word_t iload_q, dload_q, ram_addr_q, ram_wdata_q;
  logic  iwait_d, dwait_d, ram_req_d, ram_wen_d;
  word_t iload_d, dload_d, ram_addr_d, ram_wdata_d;

  logic d_req, i_starved;

  assign d_req     = bus.dREN | bus.dWEN;
  assign i_starved = bus.iREN && (dstreak == STREAK_W'(MAXD));

  // State, op, response and registered outputs
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      op          <= '0;
      resp        <= '0;
      dstreak     <= '0;
      iwait_q     <= 1'b1;
      dwait_q     <= 1'b1;
      iload_q     <= '0;
      dload_q     <= '0;
      ram_req_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state       <= state_d;
      op          <= op_d;
      resp        <= resp_d;
      dstreak     <= dstreak_d;
      iwait_q     <= iwait_d;
      dwait_q     <= dwait_d;
      iload_q     <= iload_d;
      dload_q     <= dload_d;
      ram_req_q   <= ram_req_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  // Next state: arbitration, op latch, streak counter, RAM completion
  always_comb begin
    state_d   = state;
    op_d      = op;
    resp_d    = resp;
    dstreak_d = dstreak;
    case (state)
      IDLE: begin
        if (d_req && !i_starved) begin
          state_d = SERV;
          op_d    = '{owner: OWNER_D, wen: bus.dWEN, addr: bus.daddr, wdata: bus.dstore};
          if (bus.iREN)
            dstreak_d = (dstreak >= STREAK_W'(MAXD)) ? STREAK_W'(MAXD) : dstreak + STREAK_W'(1);
          else
            dstreak_d = '0;
        end else if (bus.iREN) begin
          state_d   = SERV;
          op_d      = '{owner: OWNER_I, wen: 1'b0, addr: bus.iaddr, wdata: '0};
          dstreak_d = '0;
        end
      end
      SERV: begin
        if (bus.ram_ready) begin
          resp_d  = bus.ram_rdata;
          state_d = (op.owner == OWNER_D) ? DRESP : IRESP;
        end
      end
      IRESP:   state_d = IDLE;
      DRESP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs follow the upcoming state so they register with no path from request inputs
  always_comb begin
    iwait_d     = (state_d != IRESP);
    dwait_d     = (state_d != DRESP);
    iload_d     = (state_d == IRESP) ? resp_d : iload_q;
    dload_d     = dload_q;
    if (state_d == DRESP)
      dload_d   = op_d.wen ? '0 : resp_d;
    ram_req_d   = (state_d == SERV);
    ram_wen_d   = op_d.wen;
    ram_addr_d  = op_d.addr;
    ram_wdata_d = op_d.wdata;
  end

  assign bus.iwait     = iwait_q;
  assign bus.dwait     = dwait_q;
  assign bus.iload     = iload_q;
  assign bus.dload     = dload_q;
  assign bus.ram_req   = ram_req_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder: latency, stalls, arbitration, streak limit, reset.
module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  cache_mem_responder_if bus();

  cache_mem_responder #(.MAXD(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int    stall = 0;
  int    cnt   = 0;
  logic  model_ready = 1'b0;
  logic  inj_ready   = 1'b0;
  word_t grants[$];

  assign bus.ram_ready = model_ready | inj_ready;

  // RAM model: ready pulses after 'stall' extra SERV cycles
  always @(negedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt = 0;
      model_ready = 1'b0;
    end else if (bus.ram_req && !model_ready) begin
      if (cnt >= stall) begin
        model_ready = 1'b1;
        cnt = 0;
      end else begin
        cnt = cnt + 1;
      end
    end else begin
      model_ready = 1'b0;
    end
  end

  // Grant log by completed RAM address
  always @(posedge CLK) begin
    if (bus.ram_req && bus.ram_ready) grants.push_back(bus.ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    bus.ram_rdata = '0;

    // Reset values
    #12;
    chk1("rst_iwait", bus.iwait, 1'b1);
    chk1("rst_dwait", bus.dwait, 1'b1);
    chk("rst_iload", bus.iload, 32'h0);
    chk("rst_dload", bus.dload, 32'h0);
    chk1("rst_ram_req", bus.ram_req, 1'b0);
    chk1("rst_ram_wen", bus.ram_wen, 1'b0);
    chk("rst_ram_addr", bus.ram_addr, 32'h0);
    chk("rst_ram_wdata", bus.ram_wdata, 32'h0);
    nxt();
    nRST = 1'b1;

    // I read, zero-stall RAM
    stall = 0; bus.ram_rdata = 32'hDEADBEEF;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    nxt(); bus.iREN = 1'b0;
    smp();
    chk1("t1_req", bus.ram_req, 1'b1);
    chk("t1_addr", bus.ram_addr, 32'h40);
    chk1("t1_wen", bus.ram_wen, 1'b0);
    chk1("t1_iwait_c1", bus.iwait, 1'b1);
    nxt(); smp();
    chk1("t1_iwait_c2", bus.iwait, 1'b0);
    chk("t1_iload", bus.iload, 32'hDEADBEEF);
    nxt(); smp();
    chk1("t1_iwait_c3", bus.iwait, 1'b1);
    chk1("t1_req_c3", bus.ram_req, 1'b0);

    // D write with 3-cycle stall; inputs changed during SERV are ignored
    nxt();
    stall = 3;
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'h12345678;
    nxt();
    bus.dWEN = 1'b0; bus.daddr = 32'hDEAD0000; bus.dstore = 32'h0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk1("t2_req", bus.ram_req, 1'b1);
      chk1("t2_wen", bus.ram_wen, 1'b1);
      chk("t2_wdata", bus.ram_wdata, 32'h12345678);
      chk("t2_addr", bus.ram_addr, 32'h100);
      chk1("t2_dwait_stall", bus.dwait, 1'b1);
      nxt();
    end
    smp();
    chk1("t2_dwait", bus.dwait, 1'b0);
    chk("t2_dload", bus.dload, 32'h0);
    chk1("t2_iwait", bus.iwait, 1'b1);
    chk1("t2_req_off", bus.ram_req, 1'b0);
    nxt(); smp();
    chk1("t2_dwait_after", bus.dwait, 1'b1);

    // Simultaneous I and D: D first, then I
    nxt();
    stall = 0; bus.ram_rdata = 32'hA5A5A5A5;
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    nxt(); bus.dREN = 1'b0;
    smp();
    chk("t3_first_addr", bus.ram_addr, 32'h300);
    nxt(); smp();
    chk1("t3_dwait", bus.dwait, 1'b0);
    chk("t3_dload", bus.dload, 32'hA5A5A5A5);
    chk1("t3_iwait_d", bus.iwait, 1'b1);
    nxt(); smp();
    chk1("t3_idle_req", bus.ram_req, 1'b0);
    nxt(); bus.iREN = 1'b0;
    smp();
    chk1("t3_second_req", bus.ram_req, 1'b1);
    chk("t3_second_addr", bus.ram_addr, 32'h200);
    nxt(); smp();
    chk1("t3_iwait", bus.iwait, 1'b0);
    chk("t3_iload", bus.iload, 32'hA5A5A5A5);

    // Read+write together is a write; dload reads 0
    nxt();
    stall = 1; bus.ram_rdata = 32'h11111111;
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h8; bus.dstore = 32'hCAFEF00D;
    nxt(); bus.dREN = 1'b0; bus.dWEN = 1'b0;
    smp();
    chk1("t6_req", bus.ram_req, 1'b1);
    chk1("t6_wen", bus.ram_wen, 1'b1);
    chk("t6_addr", bus.ram_addr, 32'h8);
    chk("t6_wdata", bus.ram_wdata, 32'hCAFEF00D);
    nxt(); nxt(); smp();
    chk1("t6_dwait", bus.dwait, 1'b0);
    chk("t6_dload", bus.dload, 32'h0);

    // Streak limit: D,D,D,D,I repeating
    nxt();
    grants.delete();
    stall = 0;
    bus.iREN = 1'b1; bus.iaddr = 32'h400;
    bus.dREN = 1'b1; bus.daddr = 32'h500;
    for (int k = 0; k < 100; k++) begin
      nxt();
      if (grants.size() >= 10) break;
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    chk("t4_ngrants", 32'(grants.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_grant%0d", k),
          (grants.size() > k) ? grants[k] : 32'hFFFFFFFF,
          ((k % 5) == 4) ? 32'h400 : 32'h500);
    end
    nxt(); nxt(); smp();
    chk1("t4_idle_req", bus.ram_req, 1'b0);
    chk1("t4_idle_iwait", bus.iwait, 1'b1);
    chk1("t4_idle_dwait", bus.dwait, 1'b1);

    // Reset in SERV, then a late ready in IDLE
    nxt();
    stall = 5;
    bus.iREN = 1'b1; bus.iaddr = 32'h600;
    nxt(); bus.iREN = 1'b0;
    smp();
    chk1("t5_req_before", bus.ram_req, 1'b1);
    nxt();
    #2 nRST = 1'b0;
    #1;
    chk1("t5_req_async", bus.ram_req, 1'b0);
    chk1("t5_iwait", bus.iwait, 1'b1);
    chk1("t5_dwait", bus.dwait, 1'b1);
    chk("t5_iload", bus.iload, 32'h0);
    chk("t5_dload", bus.dload, 32'h0);
    nxt();
    nRST = 1'b1;
    inj_ready = 1'b1;
    nxt();
    inj_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk1("t5_late_req", bus.ram_req, 1'b0);
      chk1("t5_late_iwait", bus.iwait, 1'b1);
      chk1("t5_late_dwait", bus.dwait, 1'b1);
      nxt();
    end

    // Normal latency after reset shows the FSM is back in IDLE
    stall = 0; bus.ram_rdata = 32'h0BADCAFE;
    bus.dREN = 1'b1; bus.daddr = 32'h700;
    nxt(); bus.dREN = 1'b0;
    smp();
    chk1("t7_req", bus.ram_req, 1'b1);
    chk("t7_addr", bus.ram_addr, 32'h700);
    nxt(); smp();
    chk1("t7_dwait", bus.dwait, 1'b0);
    chk("t7_dload", bus.dload, 32'h0BADCAFE);

    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
